bcd_scan_display: RTL and testbench

Multiplexed N-digit seven-segment display driver. It generalises the single-digit BCD decoder with the following additions:
- parametrised digit count;
- a refresh prescaler and one-hot digit scan;
- double-buffered, tear-free loading;
- leading-zero suppression, a per-digit decimal point, and an invalid-code flag.

It sits between numeric datapaths (counters, ALU results) and the board's common-anode/cathode display pins.

---
 rtl/bcd_scan_display_if.sv | 29 ++
 rtl/bcd_scan_display.sv | 136 +++++++++++++
 tb/tb_bcd_scan_display.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Display driver bus: numeric load side in, scanned pin side out.
// Shared by the scan driver and whatever produces the digits.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [6:0]              segment;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  logic                    err_invalid;

  modport master (
    output load, bcd_in, dp_in, blank_lz,
    input  segment, dp_out, digit_en,
    input  digit_idx, frame_done, err_invalid
  );

  modport slave (
    input  load, bcd_in, dp_in, blank_lz,
    output segment, dp_out, digit_en,
    output digit_idx, frame_done, err_invalid
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Multiplexed N-digit 7-segment driver, double-buffered, tear-free.
// Define HEX_DECODE_EN to show codes 10-15 as A-F (err_invalid tied 0).
module bcd_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input logic clk,
  input logic rst,
  bcd_scan_display_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BW    = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [BW-1:0]         pend, act;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp;
  logic                  pflag;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic                  tick, wrap;
  logic [3:0]            dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;

  function automatic logic [6:0] dec(input logic [3:0] c);
    unique case (c)
      4'd0:    dec = 7'b0111111;
      4'd1:    dec = 7'b0000110;
      4'd2:    dec = 7'b1011011;
      4'd3:    dec = 7'b1001111;
      4'd4:    dec = 7'b1100110;
      4'd5:    dec = 7'b1101101;
      4'd6:    dec = 7'b1111101;
      4'd7:    dec = 7'b0000111;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1101111;
`ifdef HEX_DECODE_EN
      4'd10:   dec = 7'b1110111;
      4'd11:   dec = 7'b1111100;
      4'd12:   dec = 7'b0111001;
      4'd13:   dec = 7'b1011110;
      4'd14:   dec = 7'b1111001;
      default: dec = 7'b1110001;
`else
      default: dec = 7'b0000000;
`endif
    endcase
  endfunction

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dig[g] = act[4*g +: 4];
  end

  // lz[i]: every active digit from the top down to i is zero
  always_comb begin
    run = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run & (dig[i] == 4'd0);
      lz[i] = run;
    end
    lz[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      pend    <= '0;
      pend_dp <= '0;
      act     <= '0;
      act_dp  <= '0;
      pflag   <= 1'b0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      en_q    <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      if (wrap && bus.load) begin
        act    <= bus.bcd_in;
        act_dp <= bus.dp_in;
        pflag  <= 1'b0;
      end else if (wrap && pflag) begin
        act    <= pend;
        act_dp <= pend_dp;
        pflag  <= 1'b0;
      end else if (bus.load) begin
        pend    <= bus.bcd_in;
        pend_dp <= bus.dp_in;
        pflag   <= 1'b1;
      end
      seg_q <= (bus.blank_lz && lz[idx]) ? 7'd0 : dec(dig[idx]);
      dp_q  <= act_dp[idx];
      en_q  <= NUM_DIGITS'(1) << idx;
    end
  end

`ifdef HEX_DECODE_EN
  assign bus.err_invalid = 1'b0;
`else
  logic err_q;

  function automatic logic bad(input logic [BW-1:0] v);
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bad = bad | (v[4*i +: 4] > 4'd9);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (wrap && bus.load)
      err_q <= bad(bus.bcd_in);
    else if (wrap && pflag)
      err_q <= bad(pend);
  end

  assign bus.err_invalid = err_q;
`endif

  assign bus.segment    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.digit_en   = en_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = wrap;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (4 digits, divide-by-4).
// Reference model works from edge counts since reset release.
module tb_bcd_scan_display;
  localparam int N   = 4;
  localparam int DIV = 4;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic [1:0] idx;
    logic       fd;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q [$];

  int         k;
  logic [15:0] act, pend;
  logic [3:0]  adp, pdp;
  bit          pf, err;
  logic [6:0]  pat [16];

  bcd_scan_display_if #(.NUM_DIGITS(N)) bif ();

  bcd_scan_display #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  always #5 clk = ~clk;

  function automatic bit bad(input logic [15:0] v);
`ifdef HEX_DECODE_EN
    return 1'b0;
`else
    for (int i = 0; i < N; i++)
      if (((v >> (4*i)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic bit next_is_wrap();
    return (k % DIV == DIV-1) && ((k / DIV) % N == N-1);
  endfunction

  task automatic step(input bit r, input bit ld,
                      input logic [15:0] b,
                      input logic [3:0] d, input bit blz);
    exp_t e;
    int cb, ib;
    bit sup, wrap;
    rst          = r;
    bif.load     = ld;
    bif.bcd_in   = b;
    bif.dp_in    = d;
    bif.blank_lz = blz;
    if (r) begin
      e.seg = '0; e.dp = 0; e.en = '0;
      e.idx = '0; e.fd = 0; e.err = 0;
      k = 0; act = '0; pend = '0;
      adp = '0; pdp = '0; pf = 0; err = 0;
    end else begin
      cb = k % DIV;
      ib = (k / DIV) % N;
      k++;
      sup   = blz && ib > 0 && ((act >> (4*ib)) == 0);
      e.seg = sup ? 7'd0 : pat[int'((act >> (4*ib)) & 16'hF)];
      e.dp  = adp[ib];
      e.en  = 4'(1 << ib);
      wrap  = (cb == DIV-1) && (ib == N-1);
      if (wrap && ld) begin
        act = b; adp = d; pf = 0; err = bad(b);
      end else if (wrap && pf) begin
        act = pend; adp = pdp; pf = 0; err = bad(pend);
      end else if (ld) begin
        pend = b; pdp = d; pf = 1;
      end
      e.idx = 2'((k / DIV) % N);
      e.fd  = (k % DIV == DIV-1) && ((k / DIV) % N == N-1);
      e.err = err;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit blz);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 4'h0, blz);
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t m;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("segment",     32'(bif.segment),     32'(m.seg));
      chk("dp_out",      32'(bif.dp_out),      32'(m.dp));
      chk("digit_en",    32'(bif.digit_en),    32'(m.en));
      chk("digit_idx",   32'(bif.digit_idx),   32'(m.idx));
      chk("frame_done",  32'(bif.frame_done),  32'(m.fd));
      chk("err_invalid", 32'(bif.err_invalid), 32'(m.err));
    end
  end

  initial begin
    int n;
    logic [15:0] b;
    logic [3:0] dg;
    bit blz;
    pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
            7'b1111111, 7'b1101111,
`ifdef HEX_DECODE_EN
            7'b1110111, 7'b1111100, 7'b0111001,
            7'b1011110, 7'b1111001, 7'b1110001};
`else
            7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
`endif
    step(1, 0, 16'h0, 4'h0, 0);
    step(1, 0, 16'h0, 4'h0, 0);
    idle(40, 0);
    idle(5, 0);
    step(0, 1, 16'h1234, 4'h0, 0);
    idle(40, 0);
    step(0, 1, 16'h0070, 4'h0, 1);
    idle(36, 1);
    idle(20, 0);
    step(0, 1, 16'h00A5, 4'h0, 0);
    idle(36, 0);
    step(0, 1, 16'h0005, 4'h0, 0);
    idle(36, 0);
    step(0, 1, 16'h0000, 4'b0100, 1);
    idle(36, 1);
    while (!next_is_wrap()) idle(1, 0);
    step(0, 1, 16'h5678, 4'b0001, 0);
    idle(20, 0);
    idle(3, 0);
    step(0, 1, 16'h9999, 4'hF, 0);
    idle(2, 0);
    step(1, 0, 16'h0, 4'h0, 0);
    idle(40, 0);
    blz = 0;
    for (int i = 0; i < 3000; i++) begin
      b = '0;
      for (int j = 0; j < N; j++) begin
        n  = $urandom_range(0, 23);
        dg = (n < 16) ? 4'(n) : 4'd0;
        b  = b | (16'(dg) << (4*j));
      end
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 7) == 0,
           b, 4'($urandom), blz);
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
